fifo_stream_reader: RTL and testbench

Read-side controller for the BRAM-backed synchronous FIFO in the NLA datapath. Pops 32-bit words from the FIFO, absorbs the FIFO's fixed read latency in a small credit-controlled output buffer, and presents a valid/ready stream with frame delimiters (`sof`/`eof`) to the downstream approximation engine. Sustains one word per cycle when the FIFO is non-empty and the consumer is ready.

---
 rtl/fifo_stream_reader.sv | 157 +++++++++++++++
 tb/tb_fifo_stream_reader.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Read-side controller for the BRAM-backed FIFO. Pops words under a credit
// rule, absorbs the FIFO read latency in a small circular output buffer and
// presents a valid/ready stream with sof/eof frame delimiters.
// Optional feature macro: FIFO_STREAM_READER_MARKER_EN. When defined, a
// captured NaN frame marker (32'h7F900000) is dropped and the next buffered
// word restarts the frame.
module fifo_stream_reader #(
   parameter int RAM_WIDTH    = 32,
   parameter int READ_LATENCY = 2,
   parameter int FRAME_LEN    = 16,
   localparam int BUF_DEPTH   = READ_LATENCY + 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 fifo_empty_i,
   input  logic                 fifo_wr_en_i,
   input  logic [RAM_WIDTH-1:0] fifo_data_i,
   output logic                 fifo_rd_en_o,
   output logic                 m_valid_o,
   input  logic                 m_ready_i,
   output logic [RAM_WIDTH-1:0] m_data_o,
   output logic                 m_sof_o,
   output logic                 m_eof_o,
   output logic [15:0]          frame_cnt_o
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int WC_W  = $clog2(FRAME_LEN);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);
   localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(FRAME_LEN - 1);

   logic [READ_LATENCY-1:0] pend;
   logic [READ_LATENCY-1:0] pend_next;
   logic [PTR_W-1:0]        head;
   logic [PTR_W-1:0]        tail;
   logic [CNT_W-1:0]        occupancy;
   logic [CNT_W-1:0]        inflight;
   logic [CNT_W:0]          credit_used;
   logic [WC_W-1:0]         wcnt;
   logic [WC_W-1:0]         wcnt_eff;
   logic [RAM_WIDTH-1:0]    buf_mem [BUF_DEPTH];
   logic                    capture;
   logic                    write_en;
   logic                    handshake;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // The oldest pending pop has reached the FIFO output this cycle
   assign capture   = pend[READ_LATENCY-1];
   assign handshake = m_valid_o && m_ready_i;

`ifdef FIFO_STREAM_READER_MARKER_EN
   localparam logic [RAM_WIDTH-1:0] MARKER = RAM_WIDTH'(32'h7F90_0000);

   logic is_marker;
   logic restart_pending;
   logic restart_mem [BUF_DEPTH];

   assign is_marker = capture && (fifo_data_i == MARKER);
   assign write_en  = capture && !is_marker;
   assign wcnt_eff  = restart_mem[head] ? '0 : wcnt;

   // Remember a dropped marker until the next word is written, which then carries the frame restart
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         restart_pending <= 1'b0;
      end else if (is_marker) begin
         restart_pending <= 1'b1;
      end else if (write_en) begin
         restart_pending <= 1'b0;
      end
   end
`else
   assign write_en = capture;
   assign wcnt_eff = wcnt;
`endif

   // Popcount of outstanding pops and the next value of the latency shift register
   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         inflight = inflight + CNT_W'(pend[i]);
      end
      pend_next    = pend << 1;
      pend_next[0] = fifo_rd_en_o;
   end

   // Credit rule: never pop more than the buffer can absorb, and never against a FIFO write
   assign credit_used  = {1'b0, inflight} + {1'b0, occupancy};
   assign fifo_rd_en_o = !fifo_empty_i && !fifo_wr_en_i
                         && (credit_used < (CNT_W + 1)'(BUF_DEPTH));

   assign m_valid_o = (occupancy != '0);
   assign m_data_o  = m_valid_o ? buf_mem[head] : '0;
   assign m_sof_o   = m_valid_o && (wcnt_eff == '0);
   assign m_eof_o   = m_valid_o && (wcnt_eff == LAST_WORD);

   // Track which cycles issued a pop so the returning data can be captured
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend <= '0;
      end else begin
         pend <= pend_next;
      end
   end

   // Circular buffer pointers and occupancy; capture and handshake together leave occupancy unchanged
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
      end else begin
         if (write_en) begin
            tail <= ptr_inc(tail);
         end
         if (handshake) begin
            head <= ptr_inc(head);
         end
         case ({write_en, handshake})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   // Buffer storage needs no reset; entries are only read once written
   always_ff @(posedge clk_i) begin
      if (write_en) begin
         buf_mem[tail] <= fifo_data_i;
`ifdef FIFO_STREAM_READER_MARKER_EN
         restart_mem[tail] <= restart_pending;
`endif
      end
   end

   // Frame position advances on each handshake and wraps at eof, counting completed frames
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wcnt        <= '0;
         frame_cnt_o <= '0;
      end else if (handshake) begin
         if (m_eof_o) begin
            wcnt        <= '0;
            frame_cnt_o <= frame_cnt_o + 16'd1;
         end else begin
            wcnt <= wcnt_eff + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader. A FIFO model with a two-cycle read
// latency feeds the DUT; directed scenarios cover reset, burst framing and
// latency, back-pressure, write collisions, mid-burst reset and the NaN
// frame marker (expectations follow FIFO_STREAM_READER_MARKER_EN).
`timescale 1ns/1ps
module tb_fifo_stream_reader;

   localparam int RAM_WIDTH    = 32;
   localparam int READ_LATENCY = 2;
   localparam int FRAME_LEN    = 16;
   localparam int BUF_DEPTH    = READ_LATENCY + 2;
   localparam logic [RAM_WIDTH-1:0] MARKER = 32'h7F90_0000;
`ifdef FIFO_STREAM_READER_MARKER_EN
   localparam int MARKER_SLACK = 1;
`else
   localparam int MARKER_SLACK = 0;
`endif

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b0;
   logic                 fifo_empty_i = 1'b1;
   logic                 fifo_wr_en_i = 1'b0;
   logic [RAM_WIDTH-1:0] fifo_data_i;
   logic                 fifo_rd_en_o;
   logic                 m_valid_o;
   logic                 m_ready_i = 1'b0;
   logic [RAM_WIDTH-1:0] m_data_o;
   logic                 m_sof_o;
   logic                 m_eof_o;
   logic [15:0]          frame_cnt_o;
   logic [RAM_WIDTH-1:0] wr_data = '0;

   int assertions = 0;
   int failures   = 0;

   fifo_stream_reader #(
      .RAM_WIDTH   (RAM_WIDTH),
      .READ_LATENCY(READ_LATENCY),
      .FRAME_LEN   (FRAME_LEN)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .fifo_empty_i(fifo_empty_i),
      .fifo_wr_en_i(fifo_wr_en_i),
      .fifo_data_i (fifo_data_i),
      .fifo_rd_en_o(fifo_rd_en_o),
      .m_valid_o   (m_valid_o),
      .m_ready_i   (m_ready_i),
      .m_data_o    (m_data_o),
      .m_sof_o     (m_sof_o),
      .m_eof_o     (m_eof_o),
      .frame_cnt_o (frame_cnt_o)
   );

   // Free-running clock
   always #5 clk_i = ~clk_i;

   // FIFO model: queue storage, pops return data READ_LATENCY cycles later, reset together with the DUT
   logic [RAM_WIDTH-1:0] fifo_q [$];
   logic [RAM_WIDTH-1:0] pipe [READ_LATENCY];
   assign fifo_data_i = pipe[READ_LATENCY-1];

   always @(posedge clk_i or posedge rst_i) begin : fifo_model
      logic [RAM_WIDTH-1:0] popped;
      if (rst_i) begin
         fifo_q.delete();
         for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
         fifo_empty_i <= 1'b1;
      end else begin
         popped = 32'hDEAD_BEEF;
         if (fifo_rd_en_o && fifo_q.size() > 0) popped = fifo_q.pop_front();
         if (fifo_wr_en_i) fifo_q.push_back(wr_data);
         pipe[0] <= popped;
         for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
         fifo_empty_i <= (fifo_q.size() == 0);
      end
   end

   // Monitor: records pops, handshakes and output words mid-cycle, cleared while reset is high
   int cycle           = 0;
   int pop_cnt         = 0;
   int hs_cnt          = 0;
   int collide_cnt     = 0;
   int overflow_hits   = 0;
   int first_pop_cyc   = -1;
   int first_valid_cyc = -1;
   logic [RAM_WIDTH-1:0] rec_data [$];
   logic                 rec_sof  [$];
   logic                 rec_eof  [$];
   int                   rec_cyc  [$];

   always @(negedge clk_i) begin
      cycle <= cycle + 1;
      if (rst_i) begin
         pop_cnt         <= 0;
         hs_cnt          <= 0;
         collide_cnt     <= 0;
         first_pop_cyc   <= -1;
         first_valid_cyc <= -1;
         rec_data.delete();
         rec_sof.delete();
         rec_eof.delete();
         rec_cyc.delete();
      end else begin
         if (fifo_rd_en_o) begin
            pop_cnt <= pop_cnt + 1;
            if (first_pop_cyc < 0) first_pop_cyc <= cycle;
         end
         if (m_valid_o && first_valid_cyc < 0) first_valid_cyc <= cycle;
         if (fifo_rd_en_o && fifo_wr_en_i) collide_cnt <= collide_cnt + 1;
         if (m_valid_o && m_ready_i) begin
            hs_cnt <= hs_cnt + 1;
            rec_data.push_back(m_data_o);
            rec_sof.push_back(m_sof_o);
            rec_eof.push_back(m_eof_o);
            rec_cyc.push_back(cycle);
         end
         if ((pop_cnt + int'(fifo_rd_en_o)) - (hs_cnt + int'(m_valid_o && m_ready_i))
             > BUF_DEPTH + MARKER_SLACK)
            overflow_hits <= overflow_hits + 1;
      end
   end

   // Watchdog so a stuck DUT can never hang the run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached, failures so far %0d", failures);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic apply_reset();
      tick();
      rst_i        = 1'b1;
      fifo_wr_en_i = 1'b0;
      m_ready_i    = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   task automatic write_words(input logic [RAM_WIDTH-1:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         fifo_wr_en_i = 1'b1;
         wr_data      = base + RAM_WIDTH'(i);
      end
   endtask

   task automatic stop_writes();
      tick();
      fifo_wr_en_i = 1'b0;
   endtask

   task automatic wait_hs(input int n, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (rec_data.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      tick();
      rst_i = 1'b1;
      tick();
      assertions += 6;
      if (m_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b, expected 0", m_valid_o); end
      if (m_data_o !== '0) begin failures++; $display("[TB] FAIL reset_data: got %h, expected 0", m_data_o); end
      if (m_sof_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_sof: got %b, expected 0", m_sof_o); end
      if (m_eof_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_eof: got %b, expected 0", m_eof_o); end
      if (fifo_rd_en_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_en: got %b, expected 0", fifo_rd_en_o); end
      if (frame_cnt_o !== 16'd0) begin failures++; $display("[TB] FAIL reset_frame_cnt: got %0d, expected 0", frame_cnt_o); end
      tick();
      rst_i = 1'b0;
      repeat (3) tick();
      assertions += 2;
      if (m_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL idle_valid: got %b, expected 0", m_valid_o); end
      if (fifo_rd_en_o !== 1'b0) begin failures++; $display("[TB] FAIL idle_rd_en: got %b, expected 0", fifo_rd_en_o); end
   endtask

   task automatic test_burst();
      bit ok;
      apply_reset();
      m_ready_i = 1'b1;
      write_words(32'd0, 16);
      stop_writes();
      wait_hs(16, 60, ok);
      assertions++;
      if (ok !== 1'b1) begin
         failures++;
         $display("[TB] FAIL burst_timeout: got %0d words, expected 16", rec_data.size());
         return;
      end
      repeat (4) tick();
      assertions++;
      if (first_valid_cyc - first_pop_cyc !== 3) begin
         failures++;
         $display("[TB] FAIL burst_latency: got %0d cycles, expected 3", first_valid_cyc - first_pop_cyc);
      end
      assertions++;
      if (rec_data.size() !== 16) begin failures++; $display("[TB] FAIL burst_count: got %0d, expected 16", rec_data.size()); end
      for (int i = 0; i < 16; i++) begin
         assertions += 3;
         if (rec_data[i] !== 32'(i)) begin failures++; $display("[TB] FAIL burst_data[%0d]: got %h, expected %h", i, rec_data[i], i); end
         if (rec_sof[i] !== (i == 0)) begin failures++; $display("[TB] FAIL burst_sof[%0d]: got %b, expected %b", i, rec_sof[i], i == 0); end
         if (rec_eof[i] !== (i == 15)) begin failures++; $display("[TB] FAIL burst_eof[%0d]: got %b, expected %b", i, rec_eof[i], i == 15); end
      end
      assertions += 2;
      if (rec_cyc[15] - rec_cyc[0] !== 15) begin failures++; $display("[TB] FAIL burst_throughput: got span %0d, expected 15", rec_cyc[15] - rec_cyc[0]); end
      if (frame_cnt_o !== 16'd1) begin failures++; $display("[TB] FAIL burst_frame_cnt: got %0d, expected 1", frame_cnt_o); end
   endtask

   task automatic test_back_pressure();
      bit ok;
      apply_reset();
      write_words(32'd100, 8);
      stop_writes();
      repeat (10) tick();
      assertions += 6;
      if (pop_cnt !== BUF_DEPTH) begin failures++; $display("[TB] FAIL bp_pops: got %0d, expected %0d", pop_cnt, BUF_DEPTH); end
      if (m_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid: got %b, expected 1", m_valid_o); end
      if (m_data_o !== 32'd100) begin failures++; $display("[TB] FAIL bp_hold_data: got %h, expected %h", m_data_o, 32'd100); end
      if (m_sof_o !== 1'b1) begin failures++; $display("[TB] FAIL bp_hold_sof: got %b, expected 1", m_sof_o); end
      if (m_eof_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_hold_eof: got %b, expected 0", m_eof_o); end
      if (rec_data.size() !== 0) begin failures++; $display("[TB] FAIL bp_no_output: got %0d words, expected 0", rec_data.size()); end
      m_ready_i = 1'b1;
      wait_hs(8, 40, ok);
      assertions++;
      if (ok !== 1'b1) begin
         failures++;
         $display("[TB] FAIL bp_timeout: got %0d words, expected 8", rec_data.size());
         return;
      end
      repeat (4) tick();
      for (int i = 0; i < 8; i++) begin
         assertions += 2;
         if (rec_data[i] !== 32'(100 + i)) begin failures++; $display("[TB] FAIL bp_data[%0d]: got %h, expected %h", i, rec_data[i], 100 + i); end
         if (rec_eof[i] !== 1'b0) begin failures++; $display("[TB] FAIL bp_eof[%0d]: got %b, expected 0", i, rec_eof[i]); end
      end
      assertions += 3;
      if (rec_data.size() !== 8) begin failures++; $display("[TB] FAIL bp_count: got %0d, expected 8", rec_data.size()); end
      if (pop_cnt !== 8) begin failures++; $display("[TB] FAIL bp_total_pops: got %0d, expected 8", pop_cnt); end
      if (frame_cnt_o !== 16'd0) begin failures++; $display("[TB] FAIL bp_frame_cnt: got %0d, expected 0", frame_cnt_o); end
   endtask

   task automatic test_write_collision();
      bit ok;
      apply_reset();
      m_ready_i = 1'b1;
      write_words(32'd200, 4);
      for (int k = 0; k < 8; k++) begin
         tick();
         fifo_wr_en_i = 1'b1;
         wr_data      = 32'd204 + 32'(k);
         tick();
         fifo_wr_en_i = 1'b0;
      end
      wait_hs(12, 60, ok);
      assertions++;
      if (ok !== 1'b1) begin
         failures++;
         $display("[TB] FAIL wc_timeout: got %0d words, expected 12", rec_data.size());
         return;
      end
      repeat (4) tick();
      assertions += 3;
      if (collide_cnt !== 0) begin failures++; $display("[TB] FAIL wc_collisions: got %0d, expected 0", collide_cnt); end
      if (pop_cnt !== 12) begin failures++; $display("[TB] FAIL wc_pops: got %0d, expected 12", pop_cnt); end
      if (rec_data.size() !== 12) begin failures++; $display("[TB] FAIL wc_count: got %0d, expected 12", rec_data.size()); end
      for (int i = 0; i < 12; i++) begin
         assertions++;
         if (rec_data[i] !== 32'(200 + i)) begin failures++; $display("[TB] FAIL wc_data[%0d]: got %h, expected %h", i, rec_data[i], 200 + i); end
      end
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      apply_reset();
      write_words(32'd250, 6);
      stop_writes();
      for (int i = 0; i < 20; i++) begin
         tick();
         if (pop_cnt >= 4) break;
      end
      assertions += 2;
      if (pop_cnt !== 4) begin failures++; $display("[TB] FAIL mid_pops: got %0d, expected 4", pop_cnt); end
      if (m_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL mid_valid_before: got %b, expected 1", m_valid_o); end
      rst_i = 1'b1;
      #1;
      assertions += 6;
      if (m_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_valid: got %b, expected 0", m_valid_o); end
      if (m_data_o !== '0) begin failures++; $display("[TB] FAIL mid_data: got %h, expected 0", m_data_o); end
      if (m_sof_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_sof: got %b, expected 0", m_sof_o); end
      if (m_eof_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_eof: got %b, expected 0", m_eof_o); end
      if (fifo_rd_en_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_rd_en: got %b, expected 0", fifo_rd_en_o); end
      if (frame_cnt_o !== 16'd0) begin failures++; $display("[TB] FAIL mid_frame_cnt: got %0d, expected 0", frame_cnt_o); end
      tick();
      rst_i     = 1'b0;
      m_ready_i = 1'b1;
      write_words(32'd300, 16);
      stop_writes();
      wait_hs(16, 60, ok);
      assertions++;
      if (ok !== 1'b1) begin
         failures++;
         $display("[TB] FAIL mid_timeout: got %0d words, expected 16", rec_data.size());
         return;
      end
      repeat (4) tick();
      assertions += 6;
      if (rec_data.size() !== 16) begin failures++; $display("[TB] FAIL mid_count: got %0d, expected 16", rec_data.size()); end
      if (rec_data[0] !== 32'd300) begin failures++; $display("[TB] FAIL mid_first_data: got %h, expected %h", rec_data[0], 32'd300); end
      if (rec_sof[0] !== 1'b1) begin failures++; $display("[TB] FAIL mid_first_sof: got %b, expected 1", rec_sof[0]); end
      if (rec_data[15] !== 32'd315) begin failures++; $display("[TB] FAIL mid_last_data: got %h, expected %h", rec_data[15], 32'd315); end
      if (rec_eof[15] !== 1'b1) begin failures++; $display("[TB] FAIL mid_last_eof: got %b, expected 1", rec_eof[15]); end
      if (frame_cnt_o !== 16'd1) begin failures++; $display("[TB] FAIL mid_frame_cnt_after: got %0d, expected 1", frame_cnt_o); end
   endtask

   task automatic test_marker();
      bit ok;
      logic [RAM_WIDTH-1:0] exp_data [$];
      logic                 exp_sof  [$];
      logic                 exp_eof  [$];
      for (int i = 0; i < 5; i++) begin
         exp_data.push_back(32'd400 + 32'(i));
         exp_sof.push_back(i == 0);
         exp_eof.push_back(1'b0);
      end
`ifdef FIFO_STREAM_READER_MARKER_EN
      for (int i = 0; i < 16; i++) begin
         exp_data.push_back(32'd500 + 32'(i));
         exp_sof.push_back(i == 0);
         exp_eof.push_back(i == 15);
      end
`else
      exp_data.push_back(MARKER);
      exp_sof.push_back(1'b0);
      exp_eof.push_back(1'b0);
      for (int i = 0; i < 16; i++) begin
         exp_data.push_back(32'd500 + 32'(i));
         exp_sof.push_back(i == 10);
         exp_eof.push_back(i == 9);
      end
`endif
      apply_reset();
      m_ready_i = 1'b1;
      write_words(32'd400, 5);
      write_words(MARKER, 1);
      write_words(32'd500, 16);
      stop_writes();
      wait_hs(exp_data.size(), 80, ok);
      assertions++;
      if (ok !== 1'b1) begin
         failures++;
         $display("[TB] FAIL marker_timeout: got %0d words, expected %0d", rec_data.size(), exp_data.size());
         return;
      end
      repeat (6) tick();
      assertions += 2;
      if (rec_data.size() !== exp_data.size()) begin failures++; $display("[TB] FAIL marker_count: got %0d, expected %0d", rec_data.size(), exp_data.size()); end
      if (frame_cnt_o !== 16'd1) begin failures++; $display("[TB] FAIL marker_frame_cnt: got %0d, expected 1", frame_cnt_o); end
      for (int i = 0; i < exp_data.size(); i++) begin
         assertions += 3;
         if (rec_data[i] !== exp_data[i]) begin failures++; $display("[TB] FAIL marker_data[%0d]: got %h, expected %h", i, rec_data[i], exp_data[i]); end
         if (rec_sof[i] !== exp_sof[i]) begin failures++; $display("[TB] FAIL marker_sof[%0d]: got %b, expected %b", i, rec_sof[i], exp_sof[i]); end
         if (rec_eof[i] !== exp_eof[i]) begin failures++; $display("[TB] FAIL marker_eof[%0d]: got %b, expected %b", i, rec_eof[i], exp_eof[i]); end
      end
   endtask

   task automatic test_no_overflow();
      assertions++;
      if (overflow_hits !== 0) begin
         failures++;
         $display("[TB] FAIL buffer_overflow: got %0d overflow cycles, expected 0", overflow_hits);
      end
   endtask

   // Scenario sequence
   initial begin
      $display("[TB] fifo_stream_reader testbench start");
      test_reset();
      test_burst();
      test_back_pressure();
      test_write_collision();
      test_reset_mid_burst();
      test_marker();
      test_no_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
